// File: rtl/ece2300_stream_sink.sv
`default_nettype none
// =============================================================================
// ece2300_stream_sink : val/rdy message sink with masked compare and timeout
// Rev 1.0
// =============================================================================
module ece2300_stream_sink #(
    parameter int p_nbits   = 32,
    parameter int p_depth   = 16,
    parameter int p_timeout = 10000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [$clog2(p_depth)-1:0]   load_addr,
    input  logic [p_nbits-1:0]           load_data,
    input  logic [p_nbits-1:0]           load_mask,
    input  logic [$clog2(p_depth):0]     num_msgs,
    input  logic                         rand_en,
    input  logic                         start,
    input  logic                         recv_val,
    input  logic [p_nbits-1:0]           recv_msg,
    output logic                         recv_rdy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(p_depth)-1:0]   err_idx,
    output logic [p_nbits-1:0]           err_msg,
    output logic                         timeout,
    output logic [$clog2(p_depth):0]     count,
    output logic [31:0]                  cycles
);

    localparam int          c_aw      = $clog2(p_depth);
    localparam int          c_cw      = c_aw + 1;
    localparam logic [31:0] c_seed    = 32'hdeadbeef;
    localparam logic [31:0] c_poly    = 32'h80200003;
    localparam logic [31:0] c_timeout = 32'(p_timeout);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [p_nbits-1:0]  r_mem  [p_depth];
    logic [p_nbits-1:0]  r_mask [p_depth];

    logic [c_cw-1:0]     r_num;
    logic                r_rand;
    logic [31:0]         r_lfsr;
    logic [c_cw-1:0]     r_count;
    logic [31:0]         r_cycles;
    logic                r_done;
    logic                r_error;
    logic [c_aw-1:0]     r_err_idx;
    logic [p_nbits-1:0]  r_err_msg;
    logic                r_timeout;

    logic [c_aw-1:0]     w_idx;
    logic [c_cw-1:0]     w_count_inc;
    logic [31:0]         w_lfsr_next;
    logic                w_xfer;
    logic                w_mismatch;
    logic                w_last;
    logic                w_expire;

    assign recv_rdy    = (r_state == ST_RUN) && !(r_rand && r_lfsr[0]);
    assign w_xfer      = recv_val && recv_rdy;
    assign w_idx       = r_count[c_aw-1:0];
    assign w_count_inc = r_count + c_cw'(1);
    assign w_mismatch  = |((recv_msg ^ r_mem[w_idx]) & r_mask[w_idx]);
    assign w_last      = w_xfer && (w_count_inc == r_num);
    // Expiry is judged on the edge where cycles reaches the limit, so a run
    // lasts at most p_timeout RUN cycles.
    assign w_expire    = ((r_cycles + 32'd1) == c_timeout);
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_poly : 32'd0);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = (num_msgs == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last || w_expire) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num     <= '0;
            r_rand    <= 1'b0;
            r_lfsr    <= c_seed;
            r_count   <= '0;
            r_cycles  <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            r_err_msg <= '0;
            r_timeout <= 1'b0;
        end else if (r_state != ST_RUN) begin
            if (start) begin
                r_num     <= num_msgs;
                r_rand    <= rand_en;
                r_lfsr    <= c_seed;
                r_count   <= '0;
                r_cycles  <= '0;
                r_done    <= (num_msgs == '0);
                r_error   <= 1'b0;
                r_err_idx <= '0;
                r_err_msg <= '0;
                r_timeout <= 1'b0;
            end
        end else begin
            r_lfsr <= w_lfsr_next;
            if (r_cycles != c_timeout) begin
                r_cycles <= r_cycles + 32'd1;
            end
            if (w_xfer) begin
                r_count <= w_count_inc;
                // Only the first mismatch of a run is recorded.
                if (w_mismatch && !r_error) begin
                    r_error   <= 1'b1;
                    r_err_idx <= w_idx;
                    r_err_msg <= recv_msg;
                end
            end
            if (w_last) begin
                r_done <= 1'b1;
            end else if (w_expire) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    // Expected-message storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_en && (r_state != ST_RUN)) begin
            r_mem[load_addr]  <= load_data;
            r_mask[load_addr] <= load_mask;
        end
    end

    assign done    = r_done;
    assign error   = r_error;
    assign err_idx = r_err_idx;
    assign err_msg = r_err_msg;
    assign timeout = r_timeout;
    assign count   = r_count;
    assign cycles  = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_ece2300_stream_sink.sv
`default_nettype none
// =============================================================================
// tb_ece2300_stream_sink : vector table, corner sequences and random runs
// Rev 1.0
// =============================================================================
module tb_ece2300_stream_sink;

    localparam int NB    = 32;
    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] load_mask;
    logic [4:0]  num_msgs;
    logic        rand_en;
    logic        start;
    logic        recv_val;
    logic [31:0] recv_msg;
    logic        recv_rdy;
    logic        done;
    logic        error;
    logic [3:0]  err_idx;
    logic [31:0] err_msg;
    logic        timeout;
    logic [4:0]  count;
    logic [31:0] cycles;

    always #5 clk = ~clk;

    ece2300_stream_sink #(
        .p_nbits   (NB),
        .p_depth   (DEPTH),
        .p_timeout (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_mask (load_mask),
        .num_msgs  (num_msgs),
        .rand_en   (rand_en),
        .start     (start),
        .recv_val  (recv_val),
        .recv_msg  (recv_msg),
        .recv_rdy  (recv_rdy),
        .done      (done),
        .error     (error),
        .err_idx   (err_idx),
        .err_msg   (err_msg),
        .timeout   (timeout),
        .count     (count),
        .cycles    (cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = running, 2 = finished
    int          m_phase;
    logic [4:0]  m_count;
    logic [4:0]  m_num;
    logic        m_rand;
    logic [31:0] m_lfsr;
    logic [31:0] m_cycles;
    logic        m_done;
    logic        m_error;
    logic [3:0]  m_err_idx;
    logic [31:0] m_err_msg;
    logic        m_timeout;
    logic [31:0] m_mem  [DEPTH];
    logic [31:0] m_mask [DEPTH];

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_count = '0; m_num = '0; m_rand = 1'b0;
        m_lfsr = 32'hdeadbeef; m_cycles = '0; m_done = 1'b0;
        m_error = 1'b0; m_err_idx = '0; m_err_msg = '0; m_timeout = 1'b0;
    endtask

    function automatic logic model_rdy();
        return (m_phase == 1) && !(m_rand && m_lfsr[0]);
    endfunction

    // One clock: check rdy mid-cycle, advance the model, check outputs after the edge.
    task automatic tick();
        logic       rdy;
        logic [3:0] ix;
        @(negedge clk);
        rdy = model_rdy();
        check("recv_rdy", {63'd0, recv_rdy}, {63'd0, rdy});
        if (m_phase == 1) begin
            ix = m_count[3:0];
            if (m_cycles < TMO) m_cycles = m_cycles + 32'd1;
            m_lfsr = lfsr_step(m_lfsr);
            if (recv_val && rdy) begin
                if ((((recv_msg ^ m_mem[ix]) & m_mask[ix]) != 32'd0) && !m_error) begin
                    m_error = 1'b1; m_err_idx = ix; m_err_msg = recv_msg;
                end
                m_count = m_count + 5'd1;
            end
            if (recv_val && rdy && (m_count == m_num)) begin
                m_phase = 2; m_done = 1'b1;
            end else if (m_cycles == TMO) begin
                m_phase = 2; m_done = 1'b1; m_timeout = 1'b1;
            end
        end else begin
            if (load_en) begin
                m_mem[load_addr]  = load_data;
                m_mask[load_addr] = load_mask;
            end
            if (start) begin
                m_num = num_msgs; m_rand = rand_en; m_lfsr = 32'hdeadbeef;
                m_count = '0; m_cycles = '0; m_error = 1'b0; m_err_idx = '0;
                m_err_msg = '0; m_timeout = 1'b0;
                m_done  = (num_msgs == 5'd0);
                m_phase = (num_msgs == 5'd0) ? 2 : 1;
            end
        end
        @(posedge clk);
        #1;
        check("done",    {63'd0, done},    {63'd0, m_done});
        check("error",   {63'd0, error},   {63'd0, m_error});
        check("err_idx", {60'd0, err_idx}, {60'd0, m_err_idx});
        check("err_msg", {32'd0, err_msg}, {32'd0, m_err_msg});
        check("timeout", {63'd0, timeout}, {63'd0, m_timeout});
        check("count",   {59'd0, count},   {59'd0, m_count});
        check("cycles",  {32'd0, cycles},  {32'd0, m_cycles});
    endtask

    typedef struct packed {
        logic [0:3][31:0] data;
        logic [0:3][31:0] mask;
        logic [0:3][31:0] sent;
        logic [2:0]       n;
        logic             exp_err;
        logic [3:0]       exp_idx;
        logic [31:0]      exp_msg;
    } vec_t;

    vec_t tbl [5];

    task automatic load_and_start(input int k, input logic re);
        for (int i = 0; i < int'(tbl[k].n); i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = tbl[k].data[i];
            load_mask = tbl[k].mask[i];
            // The last entry is written on the same edge as start.
            if (i == int'(tbl[k].n) - 1) begin
                start    = 1'b1;
                num_msgs = {2'b00, tbl[k].n};
                rand_en  = re;
            end
            tick();
        end
        load_en = 1'b0;
        start   = 1'b0;
    endtask

    task automatic stream(input int k, input int max_cycles);
        for (int g = 0; g < max_cycles && m_phase == 1; g++) begin
            recv_val = 1'b1;
            recv_msg = tbl[k].sent[m_count[1:0]];
            tick();
        end
        recv_val = 1'b0;
    endtask

    task automatic run_vec(input int k, input logic re);
        load_and_start(k, re);
        stream(k, 60);
        check("vec_done",    {63'd0, done},    64'd1);
        check("vec_error",   {63'd0, error},   {63'd0, tbl[k].exp_err});
        check("vec_err_idx", {60'd0, err_idx}, {60'd0, tbl[k].exp_idx});
        check("vec_err_msg", {32'd0, err_msg}, {32'd0, tbl[k].exp_msg});
        check("vec_count",   {59'd0, count},   {61'd0, tbl[k].n});
        check("vec_timeout", {63'd0, timeout}, 64'd0);
        if (!re) check("vec_cycles", {32'd0, cycles}, {61'd0, tbl[k].n});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].data = {32'h11, 32'h22, 32'h33, 32'h44};
        tbl[0].mask = {4{32'hffffffff}};
        tbl[0].sent = {32'h11, 32'h22, 32'h33, 32'h44};
        tbl[0].n = 3'd4; tbl[0].exp_err = 1'b0; tbl[0].exp_idx = 4'd0; tbl[0].exp_msg = 32'h0;
        tbl[1] = tbl[0];
        tbl[1].sent = {32'h11, 32'h22, 32'h3f, 32'h44};
        tbl[1].exp_err = 1'b1; tbl[1].exp_idx = 4'd2; tbl[1].exp_msg = 32'h3f;
        tbl[2].data = {32'h0a, 96'h0};
        tbl[2].mask = {32'hf0, 96'h0};
        tbl[2].sent = {32'h0f, 96'h0};
        tbl[2].n = 3'd1; tbl[2].exp_err = 1'b0; tbl[2].exp_idx = 4'd0; tbl[2].exp_msg = 32'h0;
        tbl[3] = tbl[2];
        tbl[3].sent = {32'h1a, 96'h0};
        tbl[3].exp_err = 1'b1; tbl[3].exp_msg = 32'h1a;
        tbl[4] = tbl[0];
        tbl[4].sent = {32'h11, 32'h20, 32'h30, 32'h44};
        tbl[4].exp_err = 1'b1; tbl[4].exp_idx = 4'd1; tbl[4].exp_msg = 32'h20;

        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; load_mask = '0;
        num_msgs = '0; rand_en = 1'b0; start = 1'b0; recv_val = 1'b0; recv_msg = '0;
        model_reset();
        #12;
        check("rst_done",   {63'd0, done},    64'd0);
        check("rst_rdy",    {63'd0, recv_rdy},64'd0);
        check("rst_count",  {59'd0, count},   64'd0);
        check("rst_cycles", {32'd0, cycles},  64'd0);
        check("rst_error",  {63'd0, error},   64'd0);
        reset = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            load_en = 1'b1; load_addr = 4'(a); load_data = '0; load_mask = '0;
            tick();
        end
        load_en = 1'b0;

        for (int k = 0; k < 5; k++) run_vec(k, 1'b0);

        // Random back-pressure, same stream twice
        run_vec(0, 1'b1);
        run_vec(0, 1'b1);

        // No transfers after done
        recv_val = 1'b1; recv_msg = 32'h11;
        tick(); tick();
        check("post_done_count", {59'd0, count}, 64'd4);
        recv_val = 1'b0;

        // Timeout with no valid data
        start = 1'b1; num_msgs = 5'd4; rand_en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < TMO - 1; i++) tick();
        check("tmo_not_yet", {63'd0, done}, 64'd0);
        tick();
        check("tmo_done",    {63'd0, done},     64'd1);
        check("tmo_flag",    {63'd0, timeout},  64'd1);
        check("tmo_count",   {59'd0, count},    64'd0);
        check("tmo_cycles",  {32'd0, cycles},   64'd20);
        tick();
        check("tmo_rdy_low", {63'd0, recv_rdy}, 64'd0);

        // Asynchronous reset after two transfers (second one mismatches)
        load_and_start(4, 1'b0);
        recv_val = 1'b1; recv_msg = 32'h11; tick();
        recv_msg = 32'h20; tick();
        check("pre_rst_error", {63'd0, error}, 64'd1);
        check("pre_rst_count", {59'd0, count}, 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count",  {59'd0, count},    64'd0);
        check("arst_cycles", {32'd0, cycles},   64'd0);
        check("arst_error",  {63'd0, error},    64'd0);
        check("arst_errmsg", {32'd0, err_msg},  64'd0);
        check("arst_rdy",    {63'd0, recv_rdy}, 64'd0);
        model_reset();
        #1;
        reset = 1'b1;
        recv_val = 1'b0;

        // Zero-length run
        start = 1'b1; num_msgs = 5'd0;
        tick();
        start = 1'b0;
        check("zero_done", {63'd0, done}, 64'd1);
        recv_val = 1'b1; recv_msg = 32'h11;
        tick(); tick();
        check("zero_count", {59'd0, count}, 64'd0);
        recv_val = 1'b0;

        // Randomised runs against the model
        for (int r = 0; r < 25; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 2) == 0) begin
                    load_en = 1'b1; load_addr = 4'(a); load_data = $urandom;
                    case ($urandom_range(0, 2))
                        0:       load_mask = 32'hffffffff;
                        1:       load_mask = $urandom;
                        default: load_mask = 32'h0;
                    endcase
                    tick();
                end
            end
            load_en = 1'b0;
            start = 1'b1; num_msgs = 5'($urandom_range(0, 6)); rand_en = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            for (int g = 0; g < 60 && m_phase == 1; g++) begin
                recv_val = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       recv_msg = $urandom;
                    1:       recv_msg = m_mem[m_count[3:0]] ^ (32'd1 << $urandom_range(0, 31));
                    default: recv_msg = m_mem[m_count[3:0]];
                endcase
                load_en   = ($urandom_range(0, 7) == 0);
                load_addr = 4'($urandom_range(0, 15));
                load_data = $urandom;
                load_mask = $urandom;
                start     = ($urandom_range(0, 15) == 0);
                num_msgs  = 5'($urandom_range(0, 6));
                tick();
            end
            recv_val = 1'b0; load_en = 1'b0; start = 1'b0;
            check("rnd_finished", {63'd0, done}, 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
